mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle main controller for the MIPS core. Decodes instr opcode/funct and
//  sequences the shared ALU, memory port, IR, PC and register file one step per
//  state. Drives alu_op[1:0] to alu_control: 00 add, 01 sub, 10 funct, 11 slt.
//  Sits between the IR and the datapath muxes; one instruction in flight at a time.
// PARAMETERS
//  MD_CYCLES  32  mult/div iteration count (used only with MC_MULDIV_EN)
//  MD_CNT_W   6   width of mult/div counter; must satisfy 2**MD_CNT_W > MD_CYCLES
// PORTS
//  clk          in   1  single clock, all state on rising edge
//  rst          in   1  synchronous, active-high reset
//  opcode       in   6  instr[31:26] from IR
//  funct        in   6  instr[5:0] from IR
//  zero         in   1  ALU zero flag (beq)
//  mem_ready    in   1  memory completes access this cycle
//  alu_op       out  2  to alu_control
//  alu_src_a    out  1  0 PC, 1 rs
//  alu_src_b    out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  i_or_d       out  1  memory address: 0 PC, 1 ALUOut
//  mem_read     out  1  memory read strobe
//  mem_write    out  1  memory write strobe
//  ir_write     out  1  load IR
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  PC load if zero
//  pc_source    out  2  00 ALU result, 01 ALUOut, 10 jump target
//  reg_dst      out  1  0 rt, 1 rd
//  mem_to_reg   out  1  0 ALUOut, 1 MDR
//  reg_write    out  1  register file write
//  illegal_op   out  1  1-cycle pulse: unsupported opcode/funct
//  md_start     out  1  1-cycle pulse starting mult/div unit (MC_MULDIV_EN only, else 0)
//  hilo_write   out  1  1-cycle pulse, HI/LO capture (MC_MULDIV_EN only, else 0)
// BEHAVIOUR
//  - rst=1: state<=FETCH, md counter<=0; every output forced 0 while rst high.
//  - Outputs: Moore decode of state, gated by mem_ready where noted. Unlisted outputs = 0.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//    Holds until mem_ready; in that cycle only: ir_write=1, pc_write=1 -> DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). Next by opcode:
//    100011/101011 -> MEM_ADDR; 000000 -> R_EXEC; 000100 -> BRANCH; 000010 -> JUMP;
//    001000 -> I_EXEC(add); 001010 -> I_EXEC(slt); other -> illegal_op=1, FETCH.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_READ (lw) / MEM_WRITE (sw).
//  - MEM_READ: mem_read=1, i_or_d=1; wait mem_ready -> MEM_WB.
//  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - MEM_WRITE: mem_write=1, i_or_d=1; wait mem_ready -> FETCH.
//  - R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB. Funct not in
//    {100000,100010,100100,100101,101010}: illegal_op=1, -> FETCH, no write.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 (addi) / 11 (slti) -> I_WB.
//  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
//  - JUMP: pc_write=1, pc_source=10 -> FETCH.
//  - Cycles at zero wait: beq/j 3, R/addi/slti/sw 4, lw 5; +1 per mem_ready=0 cycle.
//  - mem_read/mem_write stay high, address stable, for all wait cycles.
//  - rst mid-instruction: abandon at once; no reg_write/mem_write/pc_write on the reset edge.
//  - Unused state encodings -> FETCH next cycle.
// CONFIGURATION
//  MC_MULDIV_EN defined: R_EXEC with funct 011000 (mult) / 011010 (div) -> MD_BUSY.
//    md_start=1 on entry cycle. Counter loads MD_CYCLES-1, decrements each cycle.
//    At 0: hilo_write=1 -> FETCH. No reg_write. Total = MD_CYCLES+3 cycles.
//  MC_MULDIV_EN undefined: those funct codes are illegal (illegal_op pulse,
//    no write). md_start/hilo_write tied 0. No counter logic.
// STRUCTURE
//  mips_pkg: opcode/funct constants, ALUOP_* (2b) and state localparams (4b).
//  Sub-module md_sequencer (counter + done) instantiated only under MC_MULDIV_EN;
//  all other logic is flat state register plus output decode.
// TESTING
//  1 lw, mem_ready=1: FETCH,DECODE,MEM_ADDR,MEM_READ,MEM_WB; reg_write only cycle 5, mem_to_reg=1.
//  2 sw, mem_ready low 2 cycles in MEM_WRITE: mem_write high 3 cycles, i_or_d=1, then FETCH.
//  3 R add (000000/100000): alu_op=10 in R_EXEC, reg_write+reg_dst=1 in R_WB; funct 000111 -> illegal_op, no write.
//  4 beq zero=1: pc_write_cond=1, pc_source=01, alu_op=01 in cycle 3; j: pc_source=10, pc_write=1.
//  5 opcode 111111: illegal_op pulse in DECODE, FETCH next; rst in MEM_READ -> all outputs 0, FETCH after release.
//  6 MC_MULDIV_EN, mult, MD_CYCLES=4: md_start cycle 4, hilo_write cycle 7; undefined -> illegal_op.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared constants, state encoding and control-word layout for the multi-cycle MIPS controller.
package mc_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_MD_BUSY   = 4'd12
  } state_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       md_start;
    logic       hilo_write;
  } ctrl_t;

  function automatic logic is_alu_funct(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic logic is_md_funct(input logic [5:0] fn);
    return fn inside {FN_MULT, FN_DIV};
  endfunction

endpackage

// File: rtl/mc_control_fsm_md_sequencer.sv
// Mult/div iteration counter: loads MD_CYCLES-1 on start, counts down to zero.
// Instantiated by mc_control_fsm only when MC_MULDIV_EN is defined.
module mc_control_fsm_md_sequencer #(
  parameter int MD_CYCLES = 32,
  parameter int MD_CNT_W  = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic first_o,
  output logic done_o
);

  logic [MD_CNT_W-1:0] cnt_q;
  logic                first_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      first_q <= load_i;
      if (load_i)
        cnt_q <= MD_CNT_W'(MD_CYCLES - 1);
      else if (cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  assign first_o = first_q;
  assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: one state per datapath step, outputs decoded from state.
// Optional mult/div sequencing is enabled by defining MC_MULDIV_EN.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int MD_CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       md_start,
  output logic       hilo_write
);

  if ((2 ** MD_CNT_W) <= MD_CYCLES || MD_CYCLES < 1) begin : g_bad_md_cfg
    $error("mc_control_fsm: MD_CNT_W too narrow for MD_CYCLES");
  end

  state_e state_q, state_d;
  ctrl_t  ctrl;

  // The branch decision is made in the datapath from pc_write_cond and zero.
  logic zero_unused;
  assign zero_unused = zero;

`ifdef MC_MULDIV_EN
  logic md_load, md_first, md_done;

  mc_control_fsm_md_sequencer #(
    .MD_CYCLES (MD_CYCLES),
    .MD_CNT_W  (MD_CNT_W)
  ) u_md_seq (
    .clk     (clk),
    .rst     (rst),
    .load_i  (md_load),
    .first_o (md_first),
    .done_o  (md_done)
  );
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
`ifdef MC_MULDIV_EN
    md_load = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = S_R_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
        if (is_alu_funct(funct)) begin
          state_d = S_R_WB;
`ifdef MC_MULDIV_EN
        end else if (is_md_funct(funct)) begin
          md_load = 1'b1;
          state_d = S_MD_BUSY;
`endif
        end else begin
          ctrl.illegal_op = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
        state_d        = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_d        = S_FETCH;
      end
`ifdef MC_MULDIV_EN
      S_MD_BUSY: begin
        ctrl.md_start = md_first;
        if (md_done) begin
          ctrl.hilo_write = 1'b1;
          state_d         = S_FETCH;
        end
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // Reset overrides the decode so nothing is written on the reset edge.
    if (rst) ctrl = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign alu_op        = ctrl.alu_op;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign illegal_op    = ctrl.illegal_op;
  assign md_start      = ctrl.md_start;
  assign hilo_write    = ctrl.hilo_write;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: each instruction is expanded into a queue of
// expected per-cycle control words, and every cycle's outputs are compared against it.
module tb_mc_control_fsm;

  localparam int MD_CYC = 4;
`ifdef MC_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // Output word layout, LSB first.
  localparam int P_HILO  = 0;
  localparam int P_MDST  = 1;
  localparam int P_ILL   = 2;
  localparam int P_RW    = 3;
  localparam int P_M2R   = 4;
  localparam int P_RDST  = 5;
  localparam int P_PCSRC = 6;
  localparam int P_PWC   = 8;
  localparam int P_PW    = 9;
  localparam int P_IRW   = 10;
  localparam int P_MW    = 11;
  localparam int P_MR    = 12;
  localparam int P_IORD  = 13;
  localparam int P_SRCB  = 14;
  localparam int P_SRCA  = 16;
  localparam int P_AOP   = 17;

  typedef logic [18:0] vec_t;
  typedef struct {
    vec_t base;
    vec_t extra;
    bit   waits;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic       alu_src_a, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic       reg_dst, mem_to_reg, reg_write, illegal_op, md_start, hilo_write;

  vec_t       outs;
  step_t      model_q[$];
  logic       force_q[$];
  logic [5:0] cur_op = '0;
  logic [5:0] cur_fn = '0;
  int         checks = 0;
  int         failures = 0;

  mc_control_fsm #(
    .MD_CYCLES (MD_CYC),
    .MD_CNT_W  (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .illegal_op    (illegal_op),
    .md_start      (md_start),
    .hilo_write    (hilo_write)
  );

  assign outs = {alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write,
                 pc_write, pc_write_cond, pc_source, reg_dst, mem_to_reg, reg_write,
                 illegal_op, md_start, hilo_write};

  always #5 clk = ~clk;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t b1(input int p);
    return vec_t'(1) << p;
  endfunction

  function automatic vec_t fld(input int p, input logic [1:0] v);
    return vec_t'(v) << p;
  endfunction

  function automatic void push(input vec_t base, input vec_t extra, input bit waits);
    step_t s;
    s.base  = base;
    s.extra = extra;
    s.waits = waits;
    model_q.push_back(s);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, straight from the step rules.
  task automatic load_model(input logic [5:0] op, input logic [5:0] fn);
    vec_t dec, rexec;
    dec   = fld(P_SRCB, 2'b11);
    rexec = b1(P_SRCA) | fld(P_AOP, 2'b10);
    model_q.delete();
    push(b1(P_MR) | fld(P_SRCB, 2'b01), b1(P_IRW) | b1(P_PW), 1'b1);
    case (op)
      6'b100011: begin
        push(dec, '0, 1'b0);
        push(b1(P_SRCA) | fld(P_SRCB, 2'b10), '0, 1'b0);
        push(b1(P_MR) | b1(P_IORD), '0, 1'b1);
        push(b1(P_RW) | b1(P_M2R), '0, 1'b0);
      end
      6'b101011: begin
        push(dec, '0, 1'b0);
        push(b1(P_SRCA) | fld(P_SRCB, 2'b10), '0, 1'b0);
        push(b1(P_MW) | b1(P_IORD), '0, 1'b1);
      end
      6'b000000: begin
        push(dec, '0, 1'b0);
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
          push(rexec, '0, 1'b0);
          push(b1(P_RW) | b1(P_RDST), '0, 1'b0);
        end else if (MD_EN && (fn inside {6'b011000, 6'b011010})) begin
          push(rexec, '0, 1'b0);
          for (int i = 0; i < MD_CYC; i++)
            push((i == 0 ? b1(P_MDST) : vec_t'(0)) | (i == MD_CYC - 1 ? b1(P_HILO) : vec_t'(0)),
                 '0, 1'b0);
        end else begin
          push(rexec | b1(P_ILL), '0, 1'b0);
        end
      end
      6'b000100: begin
        push(dec, '0, 1'b0);
        push(b1(P_SRCA) | fld(P_AOP, 2'b01) | b1(P_PWC) | fld(P_PCSRC, 2'b01), '0, 1'b0);
      end
      6'b000010: begin
        push(dec, '0, 1'b0);
        push(b1(P_PW) | fld(P_PCSRC, 2'b10), '0, 1'b0);
      end
      6'b001000: begin
        push(dec, '0, 1'b0);
        push(b1(P_SRCA) | fld(P_SRCB, 2'b10), '0, 1'b0);
        push(b1(P_RW), '0, 1'b0);
      end
      6'b001010: begin
        push(dec, '0, 1'b0);
        push(b1(P_SRCA) | fld(P_SRCB, 2'b10) | fld(P_AOP, 2'b11), '0, 1'b0);
        push(b1(P_RW), '0, 1'b0);
      end
      default: push(dec | b1(P_ILL), '0, 1'b0);
    endcase
  endtask

  // One clock: drive just after the rising edge, compare on the falling edge.
  task automatic tick(input logic rst_v, input string tag);
    vec_t  exp;
    step_t st;
    logic  rdy;
    @(posedge clk);
    #1;
    rdy       = (force_q.size() != 0) ? force_q.pop_front() : ($urandom_range(0, 3) != 0);
    rst       = rst_v;
    mem_ready = rdy;
    zero      = 1'($urandom);
    opcode    = cur_op;
    funct     = cur_fn;
    exp       = '0;
    if (rst_v) begin
      model_q.delete();
    end else if (model_q.size() != 0) begin
      st  = model_q.pop_front();
      exp = st.base | (rdy ? st.extra : vec_t'(0));
      if (st.waits && !rdy) model_q.push_front(st);
    end
    @(negedge clk);
    check(tag, outs, exp);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int rst_at);
    int n;
    n      = 0;
    cur_op = op;
    cur_fn = fn;
    load_model(op, fn);
    while (model_q.size() != 0) begin
      tick(n == rst_at, $sformatf("op%b_fn%b_cyc%0d", op, fn, n));
      n++;
    end
  endtask

  task automatic force_ready(input int n, input logic v);
    for (int i = 0; i < n; i++) force_q.push_back(v);
  endtask

  logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] op, fn;
    int         rst_at;

    tick(1'b1, "reset0");
    tick(1'b1, "reset1");

    force_ready(5, 1'b1);
    run_instr(6'b100011, 6'b000000, -1);             // lw, no wait
    force_ready(3, 1'b1);
    force_ready(2, 1'b0);
    force_ready(1, 1'b1);
    run_instr(6'b101011, 6'b000000, -1);             // sw, two wait cycles
    force_ready(4, 1'b1);
    run_instr(6'b000000, 6'b100000, -1);             // add
    force_ready(3, 1'b1);
    run_instr(6'b000000, 6'b000111, -1);             // bad funct
    force_ready(3, 1'b1);
    run_instr(6'b000100, 6'b000000, -1);             // beq
    force_ready(3, 1'b1);
    run_instr(6'b000010, 6'b000000, -1);             // j
    force_ready(2, 1'b1);
    run_instr(6'b111111, 6'b000000, -1);             // illegal opcode
    force_ready(4, 1'b1);
    run_instr(6'b100011, 6'b000000, 3);              // reset while in MEM_READ
    tick(1'b1, "reset_hold");
    force_ready(4, 1'b1);
    run_instr(6'b001010, 6'b000000, -1);             // slti from fresh FETCH
    force_ready(8, 1'b1);
    run_instr(6'b000000, 6'b011000, -1);             // mult
    run_instr(6'b000000, 6'b011010, -1);             // div

    repeat (400) begin
      case ($urandom_range(0, 9))
        0:       op = 6'b100011;
        1:       op = 6'b101011;
        2, 3:    op = 6'b000000;
        4:       op = 6'b000100;
        5:       op = 6'b000010;
        6:       op = 6'b001000;
        7:       op = 6'b001010;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1:    fn = legal_fn[$urandom_range(0, 4)];
        2:       fn = ($urandom_range(0, 1) != 0) ? 6'b011000 : 6'b011010;
        default: fn = 6'($urandom);
      endcase
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(op, fn, rst_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
